// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - opcode decode, ALU drive and result/flag register in front of the 16-bit ALU
//
// Purpose: accepts {op, opa, opb} on a valid/ready handshake, decodes op into
// ALU control bits, drives the ALU operands for one cycle (or sixteen for a
// multiply), registers alu_out/alu_co into result and flags, and holds them
// on a second valid/ready handshake until the consumer takes them.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          request handshake; in_ready is high only in IDLE
//   op, opa, opb               opcode and operands, latched on accept
//   out_valid/out_ready        result handshake; held until out_ready
//   result, flag_z/n/c/err     registered result and flags
//   alu_a, alu_b               ALU operands (zero unless the ALU is in use)
//   alu_ci..alu_no             ALU controls ci,nb,ic,zb,na,xo,no
//   alu_out, alu_co            combinational ALU result and carry
//
// Configuration: define ALU_SEQ_MUL_EN to make op 10 a 16-step shift-and-add
// unsigned multiply (low WIDTH bits); otherwise op 10 is illegal.

module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ci,
    output logic             alu_nb,
    output logic             alu_ic,
    output logic             alu_zb,
    output logic             alu_na,
    output logic             alu_xo,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_co
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_err_q, flag_err_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [3:0]       step_q, step_d;
`endif

    // Control bits in order {ci,nb,ic,zb,na,xo,no}.
    logic [6:0] dec_ctrl;
    logic [6:0] ctrl;

    always_comb begin
        dec_ctrl = 7'b0000000;
        case (op_q)
            4'd1:    dec_ctrl = 7'b1100000;
            4'd2:    dec_ctrl = 7'b0010000;
            4'd3:    dec_ctrl = 7'b1001000;
            4'd4:    dec_ctrl = 7'b0101000;
            4'd5:    dec_ctrl = 7'b0111000;
            4'd6:    dec_ctrl = 7'b1001100;
            4'd7:    dec_ctrl = 7'b0010010;
            4'd8:    dec_ctrl = 7'b0110111;
            default: dec_ctrl = 7'b0000000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        result_d   = result_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;
        flag_c_d   = flag_c_q;
        flag_err_d = flag_err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        step_d     = step_q;
`endif
        in_ready   = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        ctrl       = 7'b0000000;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    state_d = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = opa;
                        mplier_d = opb;
                        step_d   = 4'd0;
                        flag_c_d = 1'b0;
                    end
`endif
                end
            end
            S_EXEC: begin
                // Ops 0..9 use the ALU; anything else reaching EXEC is illegal.
                if (op_q <= OP_SHL) begin
                    alu_a      = opa_q;
                    alu_b      = (op_q == OP_SHL) ? opa_q : opb_q;
                    ctrl       = dec_ctrl;
                    result_d   = alu_out;
                    flag_z_d   = (alu_out == '0);
                    flag_n_d   = alu_out[WIDTH-1];
                    flag_c_d   = alu_co;
                    flag_err_d = 1'b0;
                end else begin
                    result_d   = '0;
                    flag_z_d   = 1'b1;
                    flag_n_d   = 1'b0;
                    flag_c_d   = 1'b0;
                    flag_err_d = 1'b1;
                end
                state_d = S_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                // Partial product added through the ALU only when the current
                // multiplier bit is set; shifts are local.
                if (mplier_q[0]) begin
                    alu_a    = acc_q;
                    alu_b    = mcand_q;
                    acc_d    = alu_out;
                    flag_c_d = flag_c_q | alu_co;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    // acc_d already includes the final step's add.
                    result_d   = acc_d;
                    flag_z_d   = (acc_d == '0);
                    flag_n_d   = acc_d[WIDTH-1];
                    flag_err_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_err_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            step_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_c_q   <= flag_c_d;
            flag_err_q <= flag_err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            step_q     <= step_d;
`endif
        end
    end

    assign {alu_ci, alu_nb, alu_ic, alu_zb, alu_na, alu_xo, alu_no} = ctrl;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_err  = flag_err_q;

endmodule
